// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//
// Time-slot arbiter and sequencer for the single-ported 16-bit VRAM. Three
// requesters share the memory: video fetch (read only), the blitter engine
// and an aux port (font/audio/host). The clock alternates between video
// slots and blit slots. At most one request is granted per clock. The VRAM
// controls are registered one cycle after the grant. Read data comes back on
// a shared rd_data_o, tagged by a per-requester valid pulse, exactly three
// cycles after the ack.
//
// Handshake (all three requesters):
//   A requester raises *_sel_i with wr/addr/data and holds them stable until
//   it sees *_ack_o. *_ack_o is combinational. When it is high in cycle N, the
//   request is consumed at the clock edge that ends cycle N. The requester
//   may present its next request in cycle N+1. No acks are given while
//   reset_i is high.
//
// Timing of one granted access in cycle N:
//   N+1 : vram_sel_o/vram_wr_o/vram_addr_o/vram_data_o show the access
//   N+2 : vram_data_i carries read data and is captured at the end of N+2
//   N+3 : rd_data_o holds the data and the matching *_valid_o is high
//
// Ports:
//   clk, reset_i                 clock, synchronous active-high reset
//   blit_cycle_o                 slot indicator (0 = video slot, 1 = blit slot)
//   vid_sel_i/addr_i             video read request
//   vid_ack_o/vid_valid_o        video accept / read data valid
//   blit_sel_i/wr_i/addr_i/data_i blitter request
//   blit_ack_o/blit_valid_o      blitter accept / read data valid
//   aux_sel_i/wr_i/addr_i/data_i aux request
//   aux_ack_o/aux_valid_o        aux accept / read data valid
//   vram_sel_o/wr_o/addr_o/data_o registered VRAM controls
//   vram_data_i                  VRAM read data (cycle after a read select)
//   rd_data_o                    registered read data, shared by requesters
// ---------------------------------------------------------------------------
module vram_arbiter #(
  parameter bit          VID_SHARE  = 1'b1,
  parameter logic [15:0] CLEAR_DATA = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_i,

  output logic        blit_cycle_o,

  input  logic        vid_sel_i,
  input  logic [15:0] vid_addr_i,
  output logic        vid_ack_o,
  output logic        vid_valid_o,

  input  logic        blit_sel_i,
  input  logic        blit_wr_i,
  input  logic [15:0] blit_addr_i,
  input  logic [15:0] blit_data_i,
  output logic        blit_ack_o,
  output logic        blit_valid_o,

  input  logic        aux_sel_i,
  input  logic        aux_wr_i,
  input  logic [15:0] aux_addr_i,
  input  logic [15:0] aux_data_i,
  output logic        aux_ack_o,
  output logic        aux_valid_o,

  output logic        vram_sel_o,
  output logic        vram_wr_o,
  output logic [15:0] vram_addr_o,
  output logic [15:0] vram_data_o,
  input  logic [15:0] vram_data_i,

  output logic [15:0] rd_data_o
);

  // Requester identity. It is used for the round-robin pointer and for the
  // read-return tags.
  typedef enum logic [1:0] {
    REQ_VID  = 2'd0,
    REQ_BLIT = 2'd1,
    REQ_AUX  = 2'd2
  } req_e;

  // Round-robin memory: which of blit/aux won the last shared grant.
  req_e rr_last;

  // Grant decode for the current cycle.
  logic vid_grant;
  logic blit_grant;
  logic aux_grant;
  logic any_grant;
  logic rd_grant;
  logic shared_slot;
  req_e grant_id;

  // Read-return tag pipeline. Stage 1 covers the VRAM select cycle and
  // stage 2 covers the VRAM data cycle.
  logic t1_valid;
  req_e t1_id;
  logic t2_valid;
  req_e t2_id;

  // -------------------------------------------------------------------------
  // Grant selection
  // -------------------------------------------------------------------------
  always_comb begin
    vid_grant   = 1'b0;
    blit_grant  = 1'b0;
    aux_grant   = 1'b0;
    // Blit/aux may compete in every blit slot. With VID_SHARE set, they may
    // also compete in a video slot that video leaves idle.
    shared_slot = blit_cycle_o || (VID_SHARE && !vid_sel_i);

    if (!reset_i) begin
      if (!blit_cycle_o && vid_sel_i) begin
        vid_grant = 1'b1;
      end else if (shared_slot) begin
        // When blit and aux both request, the one that did not win last
        // time wins now. A lone requester always wins.
        if (blit_sel_i && (!aux_sel_i || rr_last == REQ_AUX)) begin
          blit_grant = 1'b1;
        end else if (aux_sel_i) begin
          aux_grant = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_id = REQ_VID;
    if (blit_grant) begin
      grant_id = REQ_BLIT;
    end else if (aux_grant) begin
      grant_id = REQ_AUX;
    end
  end

  assign any_grant = vid_grant | blit_grant | aux_grant;
  // Video accesses are always reads.
  assign rd_grant  = vid_grant
                   | (blit_grant & ~blit_wr_i)
                   | (aux_grant  & ~aux_wr_i);

  assign vid_ack_o  = vid_grant;
  assign blit_ack_o = blit_grant;
  assign aux_ack_o  = aux_grant;

  // -------------------------------------------------------------------------
  // Slot phase and round-robin pointer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset_i) begin
      blit_cycle_o <= 1'b0;
      rr_last      <= REQ_AUX;
    end else begin
      blit_cycle_o <= ~blit_cycle_o;
      if (blit_grant) begin
        rr_last <= REQ_BLIT;
      end else if (aux_grant) begin
        rr_last <= REQ_AUX;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registered VRAM drive
  // -------------------------------------------------------------------------
  // With no grant, address and data hold their last values. Only select and
  // write enable drop. A video grant has no write data, so vram_data_o keeps
  // its previous value on a video access.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      vram_sel_o  <= 1'b0;
      vram_wr_o   <= 1'b0;
      vram_addr_o <= 16'h0000;
      vram_data_o <= CLEAR_DATA;
    end else begin
      vram_sel_o <= any_grant;
      vram_wr_o  <= (blit_grant & blit_wr_i) | (aux_grant & aux_wr_i);
      if (vid_grant) begin
        vram_addr_o <= vid_addr_i;
      end else if (blit_grant) begin
        vram_addr_o <= blit_addr_i;
        vram_data_o <= blit_data_i;
      end else if (aux_grant) begin
        vram_addr_o <= aux_addr_i;
        vram_data_o <= aux_data_i;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read return
  // -------------------------------------------------------------------------
  // Each read grant enters the tag pipeline. When the tag reaches stage 2,
  // vram_data_i holds that read's data. At that edge the data is captured
  // and the owner's valid pulse is registered. Reset empties the pipeline,
  // so reads that are in flight produce no valid pulse.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      t1_valid     <= 1'b0;
      t1_id        <= REQ_VID;
      t2_valid     <= 1'b0;
      t2_id        <= REQ_VID;
      rd_data_o    <= 16'h0000;
      vid_valid_o  <= 1'b0;
      blit_valid_o <= 1'b0;
      aux_valid_o  <= 1'b0;
    end else begin
      t1_valid     <= rd_grant;
      t1_id        <= grant_id;
      t2_valid     <= t1_valid;
      t2_id        <= t1_id;
      vid_valid_o  <= t2_valid && (t2_id == REQ_VID);
      blit_valid_o <= t2_valid && (t2_id == REQ_BLIT);
      aux_valid_o  <= t2_valid && (t2_id == REQ_AUX);
      if (t2_valid) begin
        rd_data_o <= vram_data_i;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
//
// Directed bench for vram_arbiter. Two instances share one clock, one reset
// and one set of request inputs:
//   s_* : VID_SHARE=1, CLEAR_DATA=16'hC1EA
//   r_* : VID_SHARE=0, CLEAR_DATA=16'h0000
// Each instance has its own VRAM model. The model returns addr + 16'h1E41
// one cycle after the address is presented, so address 16'h0100 reads
// back as 16'h1F41.
// Inputs change #1 after the rising edge. Outputs are checked #1 later.
// ---------------------------------------------------------------------------
module tb_vram_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_i;

  // ---------------- shared request inputs ----------------
  logic        vid_sel_i;
  logic [15:0] vid_addr_i;
  logic        blit_sel_i, blit_wr_i;
  logic [15:0] blit_addr_i, blit_data_i;
  logic        aux_sel_i, aux_wr_i;
  logic [15:0] aux_addr_i, aux_data_i;

  // ---------------- instance s outputs ----------------
  logic        s_blit_cycle, s_vid_ack, s_vid_valid, s_blit_ack, s_blit_valid;
  logic        s_aux_ack, s_aux_valid, s_vram_sel, s_vram_wr;
  logic [15:0] s_vram_addr, s_vram_data, s_vram_rd, s_rd_data;

  // ---------------- instance r outputs ----------------
  logic        r_blit_cycle, r_vid_ack, r_vid_valid, r_blit_ack, r_blit_valid;
  logic        r_aux_ack, r_aux_valid, r_vram_sel, r_vram_wr;
  logic [15:0] r_vram_addr, r_vram_data, r_vram_rd, r_rd_data;

  vram_arbiter #(.VID_SHARE(1'b1), .CLEAR_DATA(16'hC1EA)) dut_s (
    .clk(clk), .reset_i(reset_i), .blit_cycle_o(s_blit_cycle),
    .vid_sel_i(vid_sel_i), .vid_addr_i(vid_addr_i),
    .vid_ack_o(s_vid_ack), .vid_valid_o(s_vid_valid),
    .blit_sel_i(blit_sel_i), .blit_wr_i(blit_wr_i), .blit_addr_i(blit_addr_i),
    .blit_data_i(blit_data_i), .blit_ack_o(s_blit_ack), .blit_valid_o(s_blit_valid),
    .aux_sel_i(aux_sel_i), .aux_wr_i(aux_wr_i), .aux_addr_i(aux_addr_i),
    .aux_data_i(aux_data_i), .aux_ack_o(s_aux_ack), .aux_valid_o(s_aux_valid),
    .vram_sel_o(s_vram_sel), .vram_wr_o(s_vram_wr), .vram_addr_o(s_vram_addr),
    .vram_data_o(s_vram_data), .vram_data_i(s_vram_rd), .rd_data_o(s_rd_data)
  );

  vram_arbiter #(.VID_SHARE(1'b0), .CLEAR_DATA(16'h0000)) dut_r (
    .clk(clk), .reset_i(reset_i), .blit_cycle_o(r_blit_cycle),
    .vid_sel_i(vid_sel_i), .vid_addr_i(vid_addr_i),
    .vid_ack_o(r_vid_ack), .vid_valid_o(r_vid_valid),
    .blit_sel_i(blit_sel_i), .blit_wr_i(blit_wr_i), .blit_addr_i(blit_addr_i),
    .blit_data_i(blit_data_i), .blit_ack_o(r_blit_ack), .blit_valid_o(r_blit_valid),
    .aux_sel_i(aux_sel_i), .aux_wr_i(aux_wr_i), .aux_addr_i(aux_addr_i),
    .aux_data_i(aux_data_i), .aux_ack_o(r_aux_ack), .aux_valid_o(r_aux_valid),
    .vram_sel_o(r_vram_sel), .vram_wr_o(r_vram_wr), .vram_addr_o(r_vram_addr),
    .vram_data_o(r_vram_data), .vram_data_i(r_vram_rd), .rd_data_o(r_rd_data)
  );

  // VRAM models: the read data for an address appears one cycle after that
  // address is presented.
  always @(posedge clk) begin
    s_vram_rd <= s_vram_addr + 16'h1E41;
    r_vram_rd <= r_vram_addr + 16'h1E41;
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    vid_sel_i = 1'b0; vid_addr_i = 16'h0000;
    blit_sel_i = 1'b0; blit_wr_i = 1'b0; blit_addr_i = 16'h0000; blit_data_i = 16'h0000;
    aux_sel_i = 1'b0; aux_wr_i = 1'b0; aux_addr_i = 16'h0000; aux_data_i = 16'h0000;
  endtask

  // On return the bench is in cycle C0. reset_i is low and the outputs hold
  // their reset values.
  task automatic do_reset();
    clear_inputs();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [2:0]  exp_v   [0:31];
    logic        exp_sel [0:31];
    logic [15:0] exp_a   [0:31];
    logic        eb, ea, last_b, last_a;
    int          turn;
    logic [15:0] popped;

    clear_inputs();

    // Reset values. All requests are high, so the acks are forced low.
    vid_sel_i = 1'b1; blit_sel_i = 1'b1; aux_sel_i = 1'b1;
    reset_i = 1'b1;
    tick();
    tick();
    settle();
    chk("rst_acks_s", {s_vid_ack, s_blit_ack, s_aux_ack}, 16'h0);
    chk("rst_acks_r", {r_vid_ack, r_blit_ack, r_aux_ack}, 16'h0);
    chk("rst_blit_cycle", s_blit_cycle, 16'h0);
    chk("rst_vram_sel_wr", {s_vram_sel, s_vram_wr}, 16'h0);
    chk("rst_vram_addr", s_vram_addr, 16'h0000);
    chk("rst_vram_data_s", s_vram_data, 16'hC1EA);
    chk("rst_vram_data_r", r_vram_data, 16'h0000);
    chk("rst_rd_data", s_rd_data, 16'h0000);
    chk("rst_valids", {s_vid_valid, s_blit_valid, s_aux_valid}, 16'h0);
    clear_inputs();
    reset_i = 1'b0;

    // Four idle cycles, C0..C3.
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("idle_blit_cycle", s_blit_cycle, 16'(i % 2));
      chk("idle_vram_sel", s_vram_sel, 16'h0);
      chk("idle_acks", {s_vid_ack, s_blit_ack, s_aux_ack}, 16'h0);
      chk("idle_valids", {s_vid_valid, s_blit_valid, s_aux_valid}, 16'h0);
      tick();
    end

    // Video read in the C4 video slot, then a second read presented in the
    // C5 blit slot. The second read must wait for the C6 video slot.
    vid_sel_i = 1'b1; vid_addr_i = 16'h0100;
    settle();
    chk("vid_ack_c4", s_vid_ack, 16'h1);
    chk("vid_others_c4", {s_blit_ack, s_aux_ack}, 16'h0);
    tick(); // C5
    vid_addr_i = 16'h0200;
    settle();
    chk("vid_ack_blit_slot", s_vid_ack, 16'h0);
    chk("vid_vram_sel", s_vram_sel, 16'h1);
    chk("vid_vram_wr", s_vram_wr, 16'h0);
    chk("vid_vram_addr", s_vram_addr, 16'h0100);
    tick(); // C6
    settle();
    chk("vid_ack_c6", s_vid_ack, 16'h1);
    chk("vid_valid_early", s_vid_valid, 16'h0);
    tick(); // C7
    vid_sel_i = 1'b0;
    settle();
    chk("vid_valid_c7", s_vid_valid, 16'h1);
    chk("vid_rd_c7", s_rd_data, 16'h1F41);
    chk("vid_vram_addr2", s_vram_addr, 16'h0200);
    tick(); // C8
    settle();
    chk("vid_valid_c8", s_vid_valid, 16'h0);
    chk("vid_vram_sel_c8", s_vram_sel, 16'h0);
    tick(); // C9
    settle();
    chk("vid_valid_c9", s_vid_valid, 16'h1);
    chk("vid_rd_c9", s_rd_data, 16'h2041);
    tick(); // C10
    settle();
    chk("vid_valid_c10", s_vid_valid, 16'h0);

    // Blit and aux read continuously on instance r (VID_SHARE=0).
    // Expected grants: t=1 blit 0010, t=3 aux 0020, t=5 blit 0011,
    // t=7 aux 0021, t=9 blit 0012. Video slots give no grants.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      exp_v[i] = 3'b000; exp_sel[i] = 1'b0; exp_a[i] = 16'h0000;
    end
    exp_q.delete();
    blit_sel_i = 1'b1; blit_wr_i = 1'b0; blit_addr_i = 16'h0010;
    aux_sel_i  = 1'b1; aux_wr_i  = 1'b0; aux_addr_i  = 16'h0020;
    turn = 0; last_b = 1'b0; last_a = 1'b0;
    for (int t = 0; t < 15; t++) begin
      if (t > 0) begin
        tick();
        if (last_b) blit_addr_i = blit_addr_i + 16'h1;
        if (last_a) aux_addr_i = aux_addr_i + 16'h1;
        if (t == 10) begin
          blit_sel_i = 1'b0;
          aux_sel_i  = 1'b0;
        end
      end
      settle();
      eb = (t % 2 == 1) && (t < 10) && (turn == 0);
      ea = (t % 2 == 1) && (t < 10) && (turn == 1);
      chk("rr_acks", {r_vid_ack, r_blit_ack, r_aux_ack}, {13'h0, 1'b0, eb, ea});
      chk("rr_valids", {r_vid_valid, r_blit_valid, r_aux_valid}, {13'h0, exp_v[t]});
      if (exp_v[t] != 3'b000) begin
        popped = exp_q.pop_front();
        chk("rr_rd_data", r_rd_data, popped);
      end
      chk("rr_vram_sel", r_vram_sel, {15'h0, exp_sel[t]});
      if (exp_sel[t]) chk("rr_vram_addr", r_vram_addr, exp_a[t]);
      if (eb) begin
        exp_v[t+3] = 3'b010; exp_sel[t+1] = 1'b1; exp_a[t+1] = blit_addr_i;
        exp_q.push_back(blit_addr_i + 16'h1E41);
        turn = 1;
      end
      if (ea) begin
        exp_v[t+3] = 3'b001; exp_sel[t+1] = 1'b1; exp_a[t+1] = aux_addr_i;
        exp_q.push_back(aux_addr_i + 16'h1E41);
        turn = 0;
      end
      last_b = eb;
      last_a = ea;
    end
    chk("rr_queue_drained", 16'(exp_q.size()), 16'h0);

    // Blit write in the idle C0 video slot. Instance s takes it at once.
    // Instance r defers it to the C1 blit slot.
    do_reset();
    blit_sel_i = 1'b1; blit_wr_i = 1'b1; blit_addr_i = 16'h0004; blit_data_i = 16'h1E6F;
    settle();
    chk("share_ack_s", s_blit_ack, 16'h1);
    chk("share_ack_r", r_blit_ack, 16'h0);
    tick(); // C1
    settle();
    chk("share_sel_wr_s", {s_vram_sel, s_vram_wr}, 16'h3);
    chk("share_addr_s", s_vram_addr, 16'h0004);
    chk("share_data_s", s_vram_data, 16'h1E6F);
    chk("share_ack_r_blit", r_blit_ack, 16'h1);
    chk("share_sel_r_c1", r_vram_sel, 16'h0);
    tick(); // C2
    blit_sel_i = 1'b0; blit_wr_i = 1'b0;
    settle();
    chk("share_sel_wr_r", {r_vram_sel, r_vram_wr}, 16'h3);
    chk("share_addr_r", r_vram_addr, 16'h0004);
    chk("share_data_r", r_vram_data, 16'h1E6F);
    for (int i = 0; i < 4; i++) begin
      chk("write_no_valid",
          {s_vid_valid, s_blit_valid, s_aux_valid, r_vid_valid, r_blit_valid, r_aux_valid},
          16'h0);
      tick();
      settle();
    end

    // Video and blit both request in the C0 video slot.
    do_reset();
    vid_sel_i = 1'b1; vid_addr_i = 16'h0300;
    blit_sel_i = 1'b1; blit_wr_i = 1'b0; blit_addr_i = 16'h0040;
    settle();
    chk("vb_acks_c0", {s_vid_ack, s_blit_ack}, 16'h2);
    tick(); // C1
    vid_sel_i = 1'b0;
    settle();
    chk("vb_acks_c1", {s_vid_ack, s_blit_ack}, 16'h1);
    chk("vb_sel_c1", {s_vram_sel, s_vram_wr}, 16'h2);
    chk("vb_addr_c1", s_vram_addr, 16'h0300);
    tick(); // C2
    blit_sel_i = 1'b0;
    settle();
    chk("vb_sel_c2", {s_vram_sel, s_vram_wr}, 16'h2);
    chk("vb_addr_c2", s_vram_addr, 16'h0040);
    tick(); // C3
    settle();
    chk("vb_sel_c3", s_vram_sel, 16'h0);
    chk("vb_valids_c3", {s_vid_valid, s_blit_valid, s_aux_valid}, 16'h4);
    chk("vb_rd_c3", s_rd_data, 16'h2141);
    tick(); // C4
    settle();
    chk("vb_valids_c4", {s_vid_valid, s_blit_valid, s_aux_valid}, 16'h2);
    chk("vb_rd_c4", s_rd_data, 16'h1E81);
    tick(); // C5
    settle();
    chk("vb_valids_c5", {s_vid_valid, s_blit_valid, s_aux_valid}, 16'h0);

    // Blit read acked in C1, then reset in C2 drops it.
    do_reset();
    tick(); // C1
    blit_sel_i = 1'b1; blit_wr_i = 1'b0; blit_addr_i = 16'h0050;
    settle();
    chk("mr_blit_ack", s_blit_ack, 16'h1);
    tick(); // C2
    blit_sel_i = 1'b0;
    vid_sel_i = 1'b1; vid_addr_i = 16'h0600;
    reset_i = 1'b1;
    settle();
    chk("mr_ack_forced_low", s_vid_ack, 16'h0);
    chk("mr_sel_before_rst", s_vram_sel, 16'h1);
    chk("mr_addr_before_rst", s_vram_addr, 16'h0050);
    tick(); // C3
    settle();
    chk("mr_acks_in_rst", {s_vid_ack, s_blit_ack, s_aux_ack}, 16'h0);
    chk("mr_rst_cycle", s_blit_cycle, 16'h0);
    chk("mr_rst_sel_wr", {s_vram_sel, s_vram_wr}, 16'h0);
    chk("mr_rst_addr", s_vram_addr, 16'h0000);
    chk("mr_rst_data", s_vram_data, 16'hC1EA);
    chk("mr_rst_rd", s_rd_data, 16'h0000);
    chk("mr_rst_valids", {s_vid_valid, s_blit_valid, s_aux_valid}, 16'h0);
    tick(); // C4
    vid_sel_i = 1'b0;
    reset_i = 1'b0;
    settle();
    chk("mr_phase_restart", s_blit_cycle, 16'h0);
    chk("mr_dropped_valid", {s_vid_valid, s_blit_valid, s_aux_valid}, 16'h0);
    tick(); // C5
    blit_sel_i = 1'b1; blit_wr_i = 1'b0; blit_addr_i = 16'h0060;
    aux_sel_i  = 1'b1; aux_wr_i  = 1'b0; aux_addr_i  = 16'h0070;
    settle();
    chk("mr_phase_c5", s_blit_cycle, 16'h1);
    chk("mr_rr_reset", {s_blit_ack, s_aux_ack}, 16'h2);
    chk("mr_no_valid_c5", {s_vid_valid, s_blit_valid, s_aux_valid}, 16'h0);
    tick();
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
